// File: rtl/text_mode_pkg.sv
`default_nettype none
// ============================================================================
// Module   : text_mode_pkg
// Brief    : Shared geometry, control codes, FSM state type and addressing
//            helpers for the character-cell text renderer.
// Revision : 1.0 - initial release
// ============================================================================
package text_mode_pkg;

  localparam int COLS   = 80;
  localparam int ROWS   = 30;
  localparam int CELL_W = 8;
  localparam int CELL_H = 16;
  localparam int CELLS  = COLS * ROWS;

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_BLOCK = 8'h7F;

  localparam logic [6:0]  LAST_COL  = 7'(COLS - 1);
  localparam logic [4:0]  LAST_ROW  = 5'(ROWS - 1);
  localparam logic [11:0] LAST_CELL = 12'(CELLS - 1);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  // row*80 + col without a multiplier
  function automatic logic [11:0] cell_addr(input logic [4:0] row, input logic [6:0] col);
    return ({7'd0, row} << 6) + ({7'd0, row} << 4) + {5'd0, col};
  endfunction

  function automatic logic [4:0] row_inc(input logic [4:0] row);
    return (row == LAST_ROW) ? 5'd0 : row + 5'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/text_mode_renderer_font.sv
`default_nettype none
// ============================================================================
// Module   : font_rom_8x16
// Brief    : 8x16 glyph lookup with a registered output. 0x7F is a solid
//            block; printable glyphs occupy rows 2-11 so rows 14-15 stay clear.
// Revision : 1.0 - initial release
// ============================================================================
module font_rom_8x16
  import text_mode_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] char,
  input  logic [3:0] row,
  output logic [7:0] glyph
);

  logic [7:0] w_bits;

  // Procedurally generated glyphs for 0x21-0x7E keep the table compact
  always_comb begin
    w_bits = 8'h00;
    if (char == CH_BLOCK) begin
      w_bits = 8'hFF;
    end else if ((char > CH_SPACE) && (char < CH_BLOCK) && (row >= 4'd2) && (row <= 4'd11)) begin
      w_bits = {1'b0, char[6:0]} ^ {row, row};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      glyph <= 8'h00;
    end else begin
      glyph <= w_bits;
    end
  end

endmodule
`default_nettype wire

// File: rtl/text_mode_renderer.sv
`default_nettype none
// ============================================================================
// Module   : text_mode_renderer
// Brief    : 80x30 character buffer with cursor-driven write port and a
//            3-stage pixel pipeline producing glyph bits plus blinking cursor.
// Revision : 1.0 - initial release
// ============================================================================
module text_mode_renderer
  import text_mode_pkg::*;
#(
  parameter int BLINK_LOG2 = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] counter_x,
  input  logic [9:0] counter_y,
  input  logic       in_display,
  input  logic       wr_valid,
  input  logic [7:0] wr_char,
  output logic       wr_ready,
  output logic       pixel_on,
  output logic [6:0] cursor_x,
  output logic [4:0] cursor_y
);

  state_t r_state, w_state_nxt;
  logic [11:0] r_clr_addr, w_clr_nxt;
  logic [6:0]  r_cursor_x, w_cx_nxt;
  logic [4:0]  r_cursor_y, w_cy_nxt;
  logic        w_we;
  logic [11:0] w_waddr;
  logic [7:0]  w_wdata;
  logic        w_printable;

  logic [7:0]  r_ram [0:CELLS-1];

  logic [BLINK_LOG2-1:0] r_frame;
  logic        w_frame_start;
  logic [6:0]  r_s1_col;
  logic [4:0]  r_s1_row;
  logic [2:0]  r_s1_fx, r_s2_fx, r_s3_fx;
  logic [3:0]  r_s1_fy, r_s2_fy;
  logic        r_s1_disp, r_s2_disp, r_s3_disp;
  logic        r_s1_hit, r_s2_ul, r_s3_ul;
  logic [7:0]  r_rd_char;
  logic [7:0]  w_glyph;
  logic [11:0] w_raddr;
  logic        r_pixel;

  assign wr_ready    = (r_state == ST_IDLE);
  assign cursor_x    = r_cursor_x;
  assign cursor_y    = r_cursor_y;
  assign pixel_on    = r_pixel;
  assign w_printable = (wr_char >= CH_SPACE) && (wr_char <= CH_BLOCK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_CLEAR;
      r_clr_addr <= 12'd0;
      r_cursor_x <= 7'd0;
      r_cursor_y <= 5'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_clr_addr <= w_clr_nxt;
      r_cursor_x <= w_cx_nxt;
      r_cursor_y <= w_cy_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clr_nxt   = r_clr_addr;
    w_cx_nxt    = r_cursor_x;
    w_cy_nxt    = r_cursor_y;
    w_we        = 1'b0;
    w_waddr     = cell_addr(r_cursor_y, r_cursor_x);
    w_wdata     = CH_SPACE;
    case (r_state)
      ST_CLEAR: begin
        w_we    = 1'b1;
        w_waddr = r_clr_addr;
        if (r_clr_addr == LAST_CELL) begin
          w_state_nxt = ST_IDLE;
          w_clr_nxt   = 12'd0;
        end else begin
          w_clr_nxt = r_clr_addr + 12'd1;
        end
      end
      ST_IDLE: begin
        if (wr_valid) begin
          if (w_printable) begin
            w_we    = 1'b1;
            w_wdata = wr_char;
            if (r_cursor_x == LAST_COL) begin
              w_cx_nxt = 7'd0;
              w_cy_nxt = row_inc(r_cursor_y);
            end else begin
              w_cx_nxt = r_cursor_x + 7'd1;
            end
          end else begin
            case (wr_char)
              CH_CR: begin
                w_cx_nxt = 7'd0;
                w_cy_nxt = row_inc(r_cursor_y);
              end
              CH_BS: begin
                if ((r_cursor_x != 7'd0) || (r_cursor_y != 5'd0)) begin
                  if (r_cursor_x == 7'd0) begin
                    w_cx_nxt = LAST_COL;
                    w_cy_nxt = r_cursor_y - 5'd1;
                  end else begin
                    w_cx_nxt = r_cursor_x - 7'd1;
                  end
                  // Erase lands on the cell the cursor moves onto
                  w_we    = 1'b1;
                  w_waddr = cell_addr(w_cy_nxt, w_cx_nxt);
                end
              end
              CH_FF: begin
                w_cx_nxt    = 7'd0;
                w_cy_nxt    = 5'd0;
                w_state_nxt = ST_CLEAR;
                w_clr_nxt   = 12'd0;
              end
              default: ;
            endcase
          end
        end
      end
      default: w_state_nxt = ST_CLEAR;
    endcase
  end

  // Read-before-write: a same-cycle read of the written cell sees old data
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_ram[w_waddr] <= w_wdata;
    end
  end

  assign w_frame_start = (counter_x == 10'd0) && (counter_y == 10'd0);
  assign w_raddr       = cell_addr(r_s1_row, r_s1_col);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame   <= '0;
      r_s1_col  <= 7'd0;
      r_s1_row  <= 5'd0;
      r_s1_fx   <= 3'd0;
      r_s1_fy   <= 4'd0;
      r_s1_disp <= 1'b0;
      r_s1_hit  <= 1'b0;
      r_rd_char <= 8'h00;
      r_s2_fx   <= 3'd0;
      r_s2_fy   <= 4'd0;
      r_s2_disp <= 1'b0;
      r_s2_ul   <= 1'b0;
      r_s3_fx   <= 3'd0;
      r_s3_disp <= 1'b0;
      r_s3_ul   <= 1'b0;
      r_pixel   <= 1'b0;
    end else begin
      if (w_frame_start) begin
        r_frame <= r_frame + BLINK_LOG2'(1);
      end
      r_s1_col  <= counter_x[9:3];
      r_s1_row  <= counter_y[8:4];
      r_s1_fx   <= counter_x[2:0];
      r_s1_fy   <= counter_y[3:0];
      r_s1_disp <= in_display;
      // Cursor match and blink phase are captured together with the counters
      r_s1_hit  <= (counter_x[9:3] == r_cursor_x) && (counter_y[8:4] == r_cursor_y)
                   && r_frame[BLINK_LOG2-1];
      r_rd_char <= r_ram[w_raddr];
      r_s2_fx   <= r_s1_fx;
      r_s2_fy   <= r_s1_fy;
      r_s2_disp <= r_s1_disp;
      r_s2_ul   <= r_s1_hit && (r_s1_fy >= 4'd14);
      r_s3_fx   <= r_s2_fx;
      r_s3_disp <= r_s2_disp;
      r_s3_ul   <= r_s2_ul;
      r_pixel   <= r_s3_disp & (w_glyph[3'd7 - r_s3_fx] ^ r_s3_ul);
    end
  end

  font_rom_8x16 u_font (
    .clk   (clk),
    .rst_n (rst_n),
    .char  (r_rd_char),
    .row   (r_s2_fy),
    .glyph (w_glyph)
  );

endmodule
`default_nettype wire

// File: tb/tb_text_mode_renderer.sv
`default_nettype none
// ============================================================================
// Module   : tb_text_mode_renderer
// Brief    : Directed self-checking bench with a cell/cursor-level screen model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_text_mode_renderer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] counter_x, counter_y;
  logic       in_display, wr_valid;
  logic [7:0] wr_char;
  logic       wr_ready, pixel_on;
  logic [6:0] cursor_x;
  logic [4:0] cursor_y;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  text_mode_renderer #(.BLINK_LOG2(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .counter_x  (counter_x),
    .counter_y  (counter_y),
    .in_display (in_display),
    .wr_valid   (wr_valid),
    .wr_char    (wr_char),
    .wr_ready   (wr_ready),
    .pixel_on   (pixel_on),
    .cursor_x   (cursor_x),
    .cursor_y   (cursor_y)
  );

  // Screen model: cell contents (-1 = unknown), cursor, frame count, clear progress
  int m_mem [0:2399];
  int m_cx, m_cy, m_frame, m_clr;
  bit m_clearing;
  int exp_pix [0:3];
  int s_x, s_y, o_cx, o_cy, o_fr;
  logic s_disp;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int glyph_bit(input int code, input int fy);
    if (code < 0) return -1;
    if (code == 'h7F) return 1;
    if (code > 'h20 && code < 'h7F) return (fy >= 14) ? 0 : -1;
    return 0;
  endfunction

  function automatic int predict(input int x, input int y, input logic disp,
                                 input int cx, input int cy, input int fr);
    int g, ul;
    if (!disp) return 0;
    g = glyph_bit(m_mem[(y / 16) * 80 + x / 8], y % 16);
    if (g < 0) return -1;
    ul = (x / 8 == cx && y / 16 == cy && y % 16 >= 14 && fr >= 16) ? 1 : 0;
    return g ^ ul;
  endfunction

  task automatic model_advance();
    m_cx++;
    if (m_cx == 80) begin
      m_cx = 0;
      m_cy = (m_cy + 1) % 30;
    end
  endtask

  task automatic model_write(input int c);
    if (c >= 'h20 && c <= 'h7F) begin
      m_mem[m_cy * 80 + m_cx] = c;
      model_advance();
    end else if (c == 'h0D) begin
      m_cx = 0;
      m_cy = (m_cy + 1) % 30;
    end else if (c == 'h08) begin
      if (m_cx != 0 || m_cy != 0) begin
        if (m_cx == 0) begin
          m_cx = 79;
          m_cy--;
        end else begin
          m_cx--;
        end
        m_mem[m_cy * 80 + m_cx] = 'h20;
      end
    end else if (c == 'h0C) begin
      m_cx = 0;
      m_cy = 0;
      m_clearing = 1'b1;
      m_clr = 0;
    end
  endtask

  always begin
    @(posedge clk);
    s_x = counter_x; s_y = counter_y; s_disp = in_display;
    o_cx = m_cx; o_cy = m_cy; o_fr = m_frame;
    if (!rst_n) begin
      m_cx = 0; m_cy = 0; m_frame = 0; m_clearing = 1'b1; m_clr = 0;
      for (int i = 0; i < 4; i++) exp_pix[i] = 0;
    end else begin
      if (m_clearing) begin
        m_mem[m_clr] = 'h20;
        m_clr++;
        if (m_clr == 2400) m_clearing = 1'b0;
      end else if (wr_valid) begin
        model_write(int'(wr_char));
      end
      if (s_x == 0 && s_y == 0) m_frame = (m_frame + 1) % 32;
      for (int i = 3; i > 0; i--) exp_pix[i] = exp_pix[i-1];
      exp_pix[0] = predict(s_x, s_y, s_disp, o_cx, o_cy, o_fr);
    end
    #1;
    check("wr_ready", int'(wr_ready), int'(!m_clearing));
    check("cursor_x", int'(cursor_x), m_cx);
    check("cursor_y", int'(cursor_y), m_cy);
    if (exp_pix[3] >= 0) check("pixel_on", int'(pixel_on), exp_pix[3]);
  end

  task automatic idle();
    counter_x  = 10'd700;
    counter_y  = 10'd500;
    in_display = 1'b0;
  endtask

  task automatic send(input logic [7:0] c);
    int n;
    n = 0;
    while (!wr_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!wr_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: wr_ready got 0 expected 1 at %0t", $time);
    end
    wr_valid = 1'b1;
    wr_char  = c;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic expect_clear(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!wr_ready && n < 3000);
    check(name, n, 2400);
  endtask

  task automatic render_line(input int y, input int x0, input int x1, output int ones);
    ones = 0;
    for (int x = x0; x <= x1 + 3; x++) begin
      if (x <= x1) begin
        counter_x  = 10'(x);
        counter_y  = 10'(y);
        in_display = (x < 640 && y < 480);
      end else begin
        idle();
      end
      @(negedge clk);
      if (x >= x0 + 3) ones += int'(pixel_on);
    end
  endtask

  task automatic frame_pulses(input int n);
    repeat (n) begin
      counter_x = 10'd0; counter_y = 10'd0; in_display = 1'b1;
      @(negedge clk);
      idle();
      @(negedge clk);
    end
  endtask

  initial begin
    int ones, sum;
    for (int i = 0; i < 2400; i++) m_mem[i] = -1;
    idle();
    wr_valid = 1'b0;
    wr_char  = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_ready", int'(wr_ready), 0);
    check("reset_cx", int'(cursor_x), 0);
    check("reset_cy", int'(cursor_y), 0);
    check("reset_pix", int'(pixel_on), 0);
    rst_n = 1'b1;
    expect_clear("init_clear_len");

    // Solid block at (0,0), scanned on line 0 across x = 0..8
    send(8'h7F);
    check("blk_cx", int'(cursor_x), 1);
    for (int i = 0; i < 12; i++) begin
      if (i < 9) begin
        counter_x = 10'(i); counter_y = 10'd0; in_display = 1'b1;
      end else begin
        idle();
      end
      @(negedge clk);
      check($sformatf("block_px%0d", i), int'(pixel_on), (i >= 3 && i <= 10) ? 1 : 0);
    end

    send(8'h08);
    check("bs_to_origin_cx", int'(cursor_x), 0);
    send(8'h08);
    check("bs_at_origin_cx", int'(cursor_x), 0);
    check("bs_at_origin_cy", int'(cursor_y), 0);

    repeat (80) send(8'h41);
    check("row_wrap_cx", int'(cursor_x), 0);
    check("row_wrap_cy", int'(cursor_y), 1);
    repeat (2320) send(8'h41);
    check("screen_wrap_cx", int'(cursor_x), 0);
    check("screen_wrap_cy", int'(cursor_y), 0);

    send(8'h0D);
    check("cr_cy", int'(cursor_y), 1);
    send(8'h07);
    check("ignored_cx", int'(cursor_x), 0);
    send(8'h08);
    check("bs_up_cx", int'(cursor_x), 79);
    check("bs_up_cy", int'(cursor_y), 0);
    render_line(0, 632, 639, ones);
    check("bs_cell_blank", ones, 0);

    repeat (2400) send(8'h7F);
    render_line(5, 0, 639, ones);
    check("solid_line", ones, 640);
    send(8'h0C);
    check("ff_cx", int'(cursor_x), 0);
    check("ff_cy", int'(cursor_y), 0);
    expect_clear("ff_clear_len");
    sum = 0;
    render_line(0, 0, 639, ones);   sum += ones;
    render_line(100, 0, 639, ones); sum += ones;
    render_line(479, 0, 639, ones); sum += ones;
    check("ff_blank", sum, 0);

    // Reset in IDLE, then again mid-CLEAR
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (1000) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_clear_rst_ready", int'(wr_ready), 0);
    rst_n = 1'b1;
    expect_clear("reclear_len");

    repeat (3) send(8'h0D);
    repeat (2) send(8'h20);
    check("cur_cx", int'(cursor_x), 2);
    check("cur_cy", int'(cursor_y), 3);
    frame_pulses(16);
    sum = 0;
    for (int y = 48; y < 64; y++) begin
      render_line(y, 0, 39, ones);
      sum += ones;
    end
    check("cursor_on_pixels", sum, 16);
    frame_pulses(16);
    sum = 0;
    for (int y = 60; y < 64; y++) begin
      render_line(y, 0, 39, ones);
      sum += ones;
    end
    check("cursor_off_pixels", sum, 0);

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
